// File: rtl/imu_spi_pkg.sv
// Shared definitions for the IMU SPI responder: FSM encoding, register map
// addresses and command-byte layout.
package imu_spi_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   localparam logic [6:0] ACCEL_XOUT_H = 7'h3B;
   localparam logic [6:0] ACCEL_XOUT_L = 7'h3C;
   localparam logic [6:0] ACCEL_YOUT_H = 7'h3D;
   localparam logic [6:0] ACCEL_YOUT_L = 7'h3E;
   localparam logic [6:0] ACCEL_ZOUT_H = 7'h3F;
   localparam logic [6:0] ACCEL_ZOUT_L = 7'h40;
   localparam logic [6:0] TEMP_OUT_H   = 7'h41;
   localparam logic [6:0] TEMP_OUT_L   = 7'h42;
   localparam logic [6:0] GYRO_XOUT_H  = 7'h43;
   localparam logic [6:0] GYRO_XOUT_L  = 7'h44;
   localparam logic [6:0] GYRO_YOUT_H  = 7'h45;
   localparam logic [6:0] GYRO_YOUT_L  = 7'h46;
   localparam logic [6:0] GYRO_ZOUT_H  = 7'h47;
   localparam logic [6:0] GYRO_ZOUT_L  = 7'h48;
   localparam logic [6:0] PWR_MGMT_1   = 7'h6B;
   localparam logic [6:0] WHO_AM_I     = 7'h75;

   localparam int RW_BIT = 7;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin, followed by single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_din,
   output logic o_rise,
   output logic o_fall
);

   logic [STAGES-1:0] r_sync;
   logic              r_prev;

   // Resetting to the idle level keeps a released reset from faking an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= {STAGES{RESET_VAL}};
         r_prev <= RESET_VAL;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_din};
         r_prev <= r_sync[STAGES-1];
      end
   end

   assign o_rise =  r_sync[STAGES-1] & ~r_prev;
   assign o_fall = ~r_sync[STAGES-1] &  r_prev;

endmodule

// File: rtl/imu_spi_slave.sv
// SPI mode-3 responder emulating the IMU register map; the local side refreshes
// the 128x8 register file and is told about every host write.
module imu_spi_slave import imu_spi_pkg::*; #(
   parameter int         SYNC_STAGES   = 2,
   parameter logic [6:0] WHO_AM_I_ADDR = WHO_AM_I,
   parameter logic [7:0] WHO_AM_I_VAL  = 8'h68
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sck,
   input  logic       ss,
   input  logic       mosi,
   output logic       miso,
   input  logic       upd_en,
   input  logic [6:0] upd_addr,
   input  logic [7:0] upd_data,
   output logic       wr_strobe,
   output logic [6:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       busy,
   output logic       frame_done
);

   state_t r_state, w_nextState;

   logic                   w_sckRise, w_sckFall, w_ssRise, w_ssFall;
   logic [SYNC_STAGES-1:0] r_mosiSync;
   logic                   w_mosi;

   logic [2:0] r_bitCnt;
   logic [6:0] r_rx;
   logic [7:0] r_tx;
   logic [6:0] r_ptr;
   logic       r_rw;
   logic       r_miso, r_busy, r_frameDone, r_wrStrobe;
   logic [6:0] r_wrAddr;
   logic [7:0] r_wrData;
   logic [7:0] r_regs [128];

   logic [7:0] w_rxByte;
   logic       w_byteDone;
   logic [6:0] w_loadAddr;
   logic [7:0] w_loadVal;
   logic       w_spiWe;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sckEdge (
      .clk    (clk),
      .rst    (rst),
      .i_din  (sck),
      .o_rise (w_sckRise),
      .o_fall (w_sckFall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ssEdge (
      .clk    (clk),
      .rst    (rst),
      .i_din  (ss),
      .o_rise (w_ssRise),
      .o_fall (w_ssFall)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_mosiSync <= '1;
      else     r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], mosi};
   end

   assign w_mosi     = r_mosiSync[SYNC_STAGES-1];
   assign w_rxByte   = {r_rx, w_mosi};
   assign w_byteDone = w_sckRise && (r_bitCnt == 3'd7);

   // In ADDR the load address is the byte just received; in DATA it is the next pointer.
   assign w_loadAddr = (r_state == ADDR) ? w_rxByte[6:0] : r_ptr + 7'd1;
   assign w_loadVal  = (w_loadAddr == WHO_AM_I_ADDR) ? WHO_AM_I_VAL : r_regs[w_loadAddr];
   assign w_spiWe    = (r_state == DATA) && !r_rw && w_byteDone && !w_ssRise
                       && (r_ptr != WHO_AM_I_ADDR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_ssFall) w_nextState = ADDR;
         ADDR:    if (w_byteDone) w_nextState = DATA;
         DATA:    w_nextState = DATA;
         default: w_nextState = IDLE;
      endcase
      if (w_ssRise) w_nextState = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bitCnt    <= 3'd0;
         r_rx        <= 7'd0;
         r_tx        <= 8'hFF;
         r_ptr       <= 7'd0;
         r_rw        <= 1'b0;
         r_miso      <= 1'b1;
         r_busy      <= 1'b0;
         r_frameDone <= 1'b0;
         r_wrStrobe  <= 1'b0;
         r_wrAddr    <= 7'd0;
         r_wrData    <= 8'd0;
      end else begin
         r_wrStrobe  <= 1'b0;
         r_frameDone <= 1'b0;
         if (w_ssFall) r_busy <= 1'b1;
         if (w_ssRise) begin
            r_busy      <= 1'b0;
            r_miso      <= 1'b1;
            r_frameDone <= 1'b1;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_ssFall) begin
                     r_bitCnt <= 3'd0;
                     r_tx     <= 8'hFF;
                     r_miso   <= 1'b1;
                  end
               end
               ADDR: begin
                  if (w_sckRise) begin
                     r_rx     <= w_rxByte[6:0];
                     r_bitCnt <= r_bitCnt + 3'd1;
                     if (r_bitCnt == 3'd7) begin
                        r_rw  <= w_rxByte[RW_BIT];
                        r_ptr <= w_rxByte[6:0];
                        if (w_rxByte[RW_BIT]) r_tx <= w_loadVal;
                     end
                  end
               end
               DATA: begin
                  if (w_sckFall && r_rw) begin
                     r_miso <= r_tx[7];
                     r_tx   <= {r_tx[6:0], 1'b1};
                  end
                  if (w_sckRise) begin
                     r_rx     <= w_rxByte[6:0];
                     r_bitCnt <= r_bitCnt + 3'd1;
                     if (r_bitCnt == 3'd7) begin
                        r_ptr <= r_ptr + 7'd1;
                        if (r_rw) begin
                           r_tx <= w_loadVal;
                        end else begin
                           r_wrStrobe <= 1'b1;
                           r_wrAddr   <= r_ptr;
                           r_wrData   <= w_rxByte;
                        end
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // A local update to the same address in the same cycle overrides the host write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 128; i++) r_regs[i] <= 8'h00;
      end else begin
         if (w_spiWe && !(upd_en && (upd_addr == r_ptr))) r_regs[r_ptr] <= w_rxByte;
         if (upd_en) r_regs[upd_addr] <= upd_data;
      end
   end

   assign miso       = r_miso;
   assign busy       = r_busy;
   assign frame_done = r_frameDone;
   assign wr_strobe  = r_wrStrobe;
   assign wr_addr    = r_wrAddr;
   assign wr_data    = r_wrData;

endmodule

// File: tb/tb_imu_spi_slave.sv
// Drives mode-3 SPI frames and local updates into imu_spi_slave and compares
// read bytes, write strobes and frame pulses against a register-map model.
module tb_imu_spi_slave;

   localparam int HALF = 6;

   logic       clk = 1'b0;
   logic       rst;
   logic       sck, ss, mosi, miso;
   logic       upd_en;
   logic [6:0] upd_addr;
   logic [7:0] upd_data;
   logic       wr_strobe, busy, frame_done;
   logic [6:0] wr_addr;
   logic [7:0] wr_data;

   int nChecks = 0;
   int nPassed = 0;
   int frameDoneCnt = 0;
   int collideBit = -1;
   int resetBit = -1;
   logic [6:0]  collAddr;
   logic [7:0]  collData;
   logic [7:0]  txBuf [0:7];
   logic [7:0]  rxBuf [0:7];
   logic [7:0]  modelRegs [128];
   logic [14:0] strobeQ [$];

   imu_spi_slave dut (
      .clk        (clk),
      .rst        (rst),
      .sck        (sck),
      .ss         (ss),
      .mosi       (mosi),
      .miso       (miso),
      .upd_en     (upd_en),
      .upd_addr   (upd_addr),
      .upd_data   (upd_data),
      .wr_strobe  (wr_strobe),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_strobe) strobeQ.push_back({wr_addr, wr_data});
      if (frame_done) frameDoneCnt++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got === exp) nPassed++;
      else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic updWrite(input logic [6:0] a, input logic [7:0] d);
      upd_en = 1'b1; upd_addr = a; upd_data = d;
      @(negedge clk);
      upd_en = 1'b0;
      modelRegs[a] = d;
   endtask

   // Shifts nBits of txBuf out MSB first, capturing miso at every sck rise.
   task automatic applyStimulus(input int nBits);
      ss = 1'b0;
      waitCycles(HALF);
      for (int b = 0; b < nBits; b++) begin
         if (b == resetBit) begin
            rst = 1'b1; ss = 1'b1; sck = 1'b1; mosi = 1'b1;
            #1;
            checkOutput("rstMiso", miso, 1'b1);
            checkOutput("rstBusy", busy, 1'b0);
            waitCycles(3);
            rst = 1'b0;
            resetBit = -1;
            waitCycles(HALF);
            return;
         end
         sck  = 1'b0;
         mosi = txBuf[b/8][7-(b%8)];
         waitCycles(HALF);
         sck = 1'b1;
         rxBuf[b/8][7-(b%8)] = miso;
         for (int c = 0; c < HALF; c++) begin
            if (b == collideBit && c == 2) begin
               upd_en = 1'b1; upd_addr = collAddr; upd_data = collData;
            end
            if (b == collideBit && c == 3) upd_en = 1'b0;
            @(negedge clk);
         end
      end
      ss = 1'b1;
      waitCycles(2*HALF);
   endtask

   task automatic doFrame(input int nBits);
      logic [7:0]  a;
      logic [6:0]  p;
      logic [14:0] expQ [$];
      int          fd0;
      strobeQ.delete();
      fd0 = frameDoneCnt;
      applyStimulus(nBits);
      a = txBuf[0];
      p = a[6:0];
      for (int k = 1; k < nBits/8; k++) begin
         if (a[7]) begin
            checkOutput("readByte", rxBuf[k], (p == 7'h75) ? 8'h68 : modelRegs[p]);
         end else begin
            expQ.push_back({p, txBuf[k]});
            if (p != 7'h75) modelRegs[p] = txBuf[k];
         end
         p = p + 7'd1;
      end
      if (collideBit >= 0) begin
         modelRegs[collAddr] = collData;
         collideBit = -1;
      end
      checkOutput("strobeCount", strobeQ.size(), expQ.size());
      foreach (expQ[i]) if (i < strobeQ.size()) checkOutput("strobe", strobeQ[i], expQ[i]);
      checkOutput("frameDone", frameDoneCnt - fd0, 1);
   endtask

   task automatic sendBytes(input int n, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
      txBuf[0] = b0; txBuf[1] = b1; txBuf[2] = b2; txBuf[3] = b3;
      doFrame(n*8);
   endtask

   initial begin
      int         fd0;
      logic [6:0] ra;
      for (int i = 0; i < 128; i++) modelRegs[i] = 8'h00;
      rst = 1'b1; sck = 1'b1; ss = 1'b1; mosi = 1'b1;
      upd_en = 1'b0; upd_addr = 7'd0; upd_data = 8'd0;
      waitCycles(3);
      checkOutput("resetMiso", miso, 1'b1);
      checkOutput("resetStrobe", wr_strobe, 1'b0);
      checkOutput("resetWrAddr", wr_addr, 7'd0);
      checkOutput("resetWrData", wr_data, 8'd0);
      checkOutput("resetBusy", busy, 1'b0);
      checkOutput("resetFrameDone", frame_done, 1'b0);
      rst = 1'b0;
      waitCycles(3);

      sendBytes(2, 8'hF5, 8'hFF, 8'hFF, 8'hFF);

      updWrite(7'h3B, 8'h12); updWrite(7'h3C, 8'h34); updWrite(7'h3D, 8'h56);
      sendBytes(4, 8'hBB, 8'hFF, 8'hFF, 8'hFF);

      sendBytes(2, 8'h6B, 8'h01, 8'hFF, 8'hFF);
      sendBytes(2, 8'hEB, 8'hFF, 8'hFF, 8'hFF);
      sendBytes(2, 8'h75, 8'h00, 8'hFF, 8'hFF);
      sendBytes(2, 8'hF5, 8'hFF, 8'hFF, 8'hFF);

      updWrite(7'h7F, 8'hAA); updWrite(7'h00, 8'hBB);
      sendBytes(3, 8'hFF, 8'hFF, 8'hFF, 8'hFF);

      updWrite(7'h20, 8'h5A);
      txBuf[0] = 8'h20; txBuf[1] = 8'hC3;
      doFrame(12);
      sendBytes(2, 8'hA0, 8'hFF, 8'hFF, 8'hFF);

      collideBit = 15; collAddr = 7'h10; collData = 8'h55;
      sendBytes(2, 8'h10, 8'h99, 8'hFF, 8'hFF);
      sendBytes(2, 8'h90, 8'hFF, 8'hFF, 8'hFF);

      updWrite(7'h30, 8'h00);
      txBuf[0] = 8'hB0; txBuf[1] = 8'hFF;
      fd0 = frameDoneCnt;
      resetBit = 12;
      applyStimulus(16);
      checkOutput("rstNoFrameDone", frameDoneCnt - fd0, 0);
      for (int i = 0; i < 128; i++) modelRegs[i] = 8'h00;
      sendBytes(4, 8'hBB, 8'hFF, 8'hFF, 8'hFF);
      sendBytes(2, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      sendBytes(2, 8'h6B, 8'hC7, 8'hFF, 8'hFF);
      sendBytes(2, 8'hEB, 8'hFF, 8'hFF, 8'hFF);

      for (int f = 0; f < 25; f++) begin
         repeat ($urandom_range(0, 2)) updWrite(7'($urandom_range(0, 127)), 8'($urandom));
         case ($urandom_range(0, 4))
            0:       ra = 7'h7E;
            1:       ra = 7'h74;
            2:       ra = 7'h75;
            default: ra = 7'($urandom_range(0, 127));
         endcase
         sendBytes($urandom_range(2, 4), {1'($urandom), ra}, 8'($urandom), 8'($urandom), 8'($urandom));
      end

      $display("%0d/%0d checks passed", nPassed, nChecks);
      $finish;
   end

endmodule
